// File: rtl/alu_16_seq_if.sv
// Request/response bundle between a 16-bit ALU client and alu_16_seq.
interface alu_16_seq_if;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  opcode;
    logic [15:0] result;
    logic        carry;
    logic        done;

    // Client side: issues requests, observes results.
    modport master (
        output start_valid, a, b, opcode,
        input  start_ready, result, carry, done
    );

    // Sequencer side.
    modport slave (
        input  start_valid, a, b, opcode,
        output start_ready, result, carry, done
    );
endinterface

// File: rtl/alu_16_seq.sv
// 16-bit ALU sequencer: runs a 16-bit operation through one external 8-bit
// ALU as low byte, high byte and an optional carry/borrow fix-up pass.
module alu_16_seq #(
    parameter logic [3:0] OPC_ADD = 4'h0,
    parameter logic [3:0] OPC_SUB = 4'h1,
    parameter logic [3:0] OPC_AND = 4'h2,
    parameter logic [3:0] OPC_OR  = 4'h3
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_16_seq_if.slave  bus,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [3:0]   alu_opcode,
    input  logic [7:0]   alu_out
);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  op_q;
    logic        c0;
    logic        c1;
    logic [7:0]  res_lo;
    logic [7:0]  res_hi;
    logic        is_arith;
    logic        needs_fix;

    // Byte-level carry (ADD) or borrow (SUB); bytewise logic ops never carry.
    function automatic logic byte_carry(input logic [3:0] op, input logic [7:0] x,
                                        input logic [7:0] y, input logic [7:0] r);
        case (op)
            OPC_ADD:         return r < x;
            OPC_SUB:         return x < y;
            OPC_AND, OPC_OR: return 1'b0;
            default:         return 1'b0;
        endcase
    endfunction

    assign is_arith  = (op_q == OPC_ADD) || (op_q == OPC_SUB);
    assign needs_fix = is_arith && c0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and 8-bit ALU drive.
    always_comb begin
        state_nxt       = state;
        bus.start_ready = 1'b0;
        bus.done        = 1'b0;
        alu_a           = '0;
        alu_b           = '0;
        alu_opcode      = '0;
        case (state)
            IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid) state_nxt = LO;
            end
            LO: begin
                alu_a      = a_q[7:0];
                alu_b      = b_q[7:0];
                alu_opcode = op_q;
                state_nxt  = HI;
            end
            HI: begin
                alu_a      = a_q[15:8];
                alu_b      = b_q[15:8];
                alu_opcode = op_q;
                state_nxt  = needs_fix ? FIX : DONE;
            end
            FIX: begin
                alu_a      = res_hi;
                alu_b      = 8'h01;
                alu_opcode = op_q;
                state_nxt  = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-byte datapath.
    // result/carry are loaded on the edge entering DONE (from HI or FIX) so
    // they are already valid during the cycle in which done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            c0         <= 1'b0;
            c1         <= 1'b0;
            res_lo     <= '0;
            res_hi     <= '0;
            bus.result <= '0;
            bus.carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q  <= bus.a;
                        b_q  <= bus.b;
                        op_q <= bus.opcode;
                    end
                end
                LO: begin
                    res_lo <= alu_out;
                    c0     <= byte_carry(op_q, a_q[7:0], b_q[7:0], alu_out);
                end
                HI: begin
                    res_hi <= alu_out;
                    c1     <= byte_carry(op_q, a_q[15:8], b_q[15:8], alu_out);
                    if (!needs_fix) begin
                        bus.result <= {alu_out, res_lo};
                        bus.carry  <= byte_carry(op_q, a_q[15:8], b_q[15:8], alu_out);
                    end
                end
                FIX: begin
                    res_hi     <= alu_out;
                    c1         <= c1 | ((op_q == OPC_ADD) && (res_hi == 8'hFF))
                                     | ((op_q == OPC_SUB) && (res_hi == 8'h00));
                    bus.result <= {alu_out, res_lo};
                    bus.carry  <= c1 | ((op_q == OPC_ADD) && (res_hi == 8'hFF))
                                     | ((op_q == OPC_SUB) && (res_hi == 8'h00));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_16_seq.sv
// Scoreboard bench for alu_16_seq with a behavioural alu_8 on the byte port.
module tb_alu_16_seq;

    logic        clk;
    logic        rst_n;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_out;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [15:0] res;
        logic        c;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    alu_16_seq_if bus ();

    alu_16_seq #(
        .OPC_ADD(4'h0),
        .OPC_SUB(4'h1),
        .OPC_AND(4'h2),
        .OPC_OR (4'h3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opcode(alu_opcode),
        .alu_out   (alu_out)
    );

    // Behavioural alu_8.
    always_comb begin
        case (alu_opcode)
            4'h0:    alu_out = alu_a + alu_b;
            4'h1:    alu_out = alu_a - alu_b;
            4'h2:    alu_out = alu_a & alu_b;
            4'h3:    alu_out = alu_a | alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (bus.done) begin
            exp_t e;
            chk("done_not_ready", {31'd0, bus.start_ready}, 32'd0);
            chk("done_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", {16'd0, bus.result}, {16'd0, e.res});
                chk("carry", {31'd0, bus.carry}, {31'd0, e.c});
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !bus.start_ready; i++) @(negedge clk);
        chk("ready_before", {31'd0, bus.start_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [3:0] op,
                          input logic [15:0] er, input logic ec, input bit fix, input bit busy);
        exp_t        e;
        int unsigned n;
        @(negedge clk);
        wait_ready();
        n = cyc;
        bus.start_valid = 1'b1;
        bus.a           = ta;
        bus.b           = tb_v;
        bus.opcode      = op;
        e.res = er;
        e.c   = ec;
        e.cyc = n + (fix ? 4 : 3);
        sb.push_back(e);
        @(negedge clk);
        // LO: scramble inputs; optionally keep requesting while busy.
        bus.start_valid = busy;
        bus.a           = ~ta;
        bus.b           = ta ^ tb_v ^ 16'h5A5A;
        bus.opcode      = op ^ 4'h1;
        chk("lo_alu_a", {24'd0, alu_a}, {24'd0, ta[7:0]});
        chk("lo_alu_b", {24'd0, alu_b}, {24'd0, tb_v[7:0]});
        chk("lo_alu_op", {28'd0, alu_opcode}, {28'd0, op});
        chk("lo_ready", {31'd0, bus.start_ready}, 32'd0);
        @(negedge clk);
        chk("hi_alu_a", {24'd0, alu_a}, {24'd0, ta[15:8]});
        chk("hi_alu_b", {24'd0, alu_b}, {24'd0, tb_v[15:8]});
        chk("hi_alu_op", {28'd0, alu_opcode}, {28'd0, op});
        chk("hi_ready", {31'd0, bus.start_ready}, 32'd0);
        if (fix) begin
            @(negedge clk);
            chk("fix_alu_b", {24'd0, alu_b}, 32'h01);
            chk("fix_alu_op", {28'd0, alu_opcode}, {28'd0, op});
            chk("fix_ready", {31'd0, bus.start_ready}, 32'd0);
        end
        @(negedge clk);
        chk("done_cycle_ready", {31'd0, bus.start_ready}, 32'd0);
        chk("done_cycle_done", {31'd0, bus.done}, 32'd1);
        bus.start_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.start_ready}, 32'd1);
        chk("idle_done", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        cyc             = 0;
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.opcode      = '0;
        #3;
        chk("rst_result", {16'd0, bus.result}, 32'd0);
        chk("rst_carry", {31'd0, bus.carry}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ready", {31'd0, bus.start_ready}, 32'd1);
        chk("rst_alu_drive", {12'd0, alu_a, alu_b, alu_opcode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      a         b         op    result    c     fix   busy
        run_op(16'h12FF, 16'h0001, 4'h0, 16'h1300, 1'b0, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(16'h1000, 16'h0001, 4'h1, 16'h0FFF, 1'b0, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0001, 4'h1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0003, 4'h1, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op(16'hF0F0, 16'h0FFF, 4'h2, 16'h00F0, 1'b0, 1'b0, 1'b0);
        run_op(16'hCB00, 16'h2B01, 4'h3, 16'hEB01, 1'b0, 1'b0, 1'b0);
        run_op(16'h0102, 16'h0304, 4'h0, 16'h0406, 1'b0, 1'b0, 1'b1);

        // Reset while the high byte of an ADD is in flight: no done expected.
        @(negedge clk);
        wait_ready();
        bus.start_valid = 1'b1;
        bus.a           = 16'h12FF;
        bus.b           = 16'h0101;
        bus.opcode      = 4'h0;
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_hi", {24'd0, alu_a}, 32'h12);
        rst_n = 1'b0;
        #1;
        chk("abort_result", {16'd0, bus.result}, 32'd0);
        chk("abort_carry", {31'd0, bus.carry}, 32'd0);
        chk("abort_ready", {31'd0, bus.start_ready}, 32'd1);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_result", {16'd0, bus.result}, 32'd0);

        run_op(16'h0007, 16'h0007, 4'h0, 16'h000E, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_16_seq.md
Name: alu_16_seq

Overview:
- Multi-cycle 16-bit arithmetic/logic sequencer and the initiator side of the alu_8 interface.
- Accepts a 16-bit operation through a valid/ready handshake and drives one external alu_8 instance byte by byte: low byte, high byte, then an optional carry/borrow fix-up pass.
- Produces a 16-bit result, a carry/borrow flag and a one-cycle done pulse.
- Used by the Z80 core for 16-bit ADD/SUB (HL/BC/DE/SP paths) and 16-bit logic, without a second ALU.

Parameters:
- OPC_ADD, 4'h0, alu_8 opcode for add
- OPC_SUB, 4'h1, alu_8 opcode for subtract
- OPC_AND, 4'h2, alu_8 opcode for AND (bytewise, no carry)
- OPC_OR, 4'h3, alu_8 opcode for OR (bytewise, no carry)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  request valid
- start_ready  out  1  high only in IDLE
- a  in  16  operand A
- b  in  16  operand B
- opcode  in  4  operation; any alu_8 opcode
- result  out  16  result, held until the next completed operation
- carry  out  1  carry (ADD) / borrow (SUB); 0 for all other opcodes
- done  out  1  one-cycle pulse; result and carry are valid in that cycle
- alu_a  out  8  to alu_8 .a
- alu_b  out  8  to alu_8 .b
- alu_opcode  out  4  to alu_8 .opcode
- alu_out  in  8  from alu_8 .out (combinational, same cycle)

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - result = 0, carry = 0, done = 0.
  - Internal latches (a_q, b_q, op_q, c0) cleared.
  - alu_a/alu_b/alu_opcode = 0.
  - start_ready = 1 whenever state is IDLE, including during reset.
- Reset mid-operation: aborts immediately. No done pulse, result returns to 0.
- IDLE:
  - ALU drive outputs are 0.
  - On clk with start_valid & start_ready: latch a, b, opcode -> LO.
- LO:
  - Drive alu_a = a_q[7:0], alu_b = b_q[7:0], alu_opcode = op_q.
  - At edge: res_lo <= alu_out.
  - c0 <= (alu_out < a_q[7:0]) if ADD; (a_q[7:0] < b_q[7:0]) if SUB; else 0.
  - Next state -> HI.
- HI:
  - Drive high bytes of a_q and b_q with op_q.
  - At edge: res_hi <= alu_out.
  - c1 computed as in LO on the high bytes.
  - If (ADD or SUB) and c0 -> FIX; else -> DONE.
- FIX:
  - Drive alu_a = res_hi, alu_b = 8'h01, alu_opcode = op_q (ADD increments, SUB decrements).
  - At edge: res_hi <= alu_out.
  - c1 <= c1 | (ADD & res_hi == 8'hFF) | (SUB & res_hi == 8'h00).
  - Next state -> DONE.
- DONE:
  - result <= {res_hi, res_lo}, carry <= c1, done = 1 for exactly this cycle.
  - Next state -> IDLE.
- Latency, counted from the accept edge to the cycle in which done is high:
  - 3 cycles without fix-up.
  - 4 cycles with fix-up.
  - Throughput is one operation per 4 (or 5) cycles.
- start_valid while not IDLE is ignored. It must not corrupt the in-flight operation and is not queued.
- Operands are sampled only at accept; later changes on a/b/opcode have no effect.
- All arithmetic wraps modulo 2^16; carry reports overflow out of bit 15 / borrow into bit 15.
- Opcodes other than ADD/SUB are applied bytewise with no fix-up pass; carry = 0.
- done and start_ready are never high in the same cycle.

Test Plan:
1. ADD a=16'h12FF, b=16'h0001 -> FIX path taken, result=16'h1300, carry=0, done 4 cycles after accept; alu_b=8'h01 during FIX.
2. ADD a=16'hFFFF, b=16'h0001 -> result=16'h0000, carry=1. ADD 16'h8000+16'h8000 -> result=16'h0000, carry=1, no FIX (3-cycle latency).
3. SUB a=16'h1000, b=16'h0001 -> result=16'h0FFF, carry=0. SUB 16'h0000-16'h0001 -> result=16'hFFFF, carry=1.
4. AND 16'hF0F0 & 16'h0FFF -> 16'h00F0; OR 16'hCB00 | 16'h2B01 -> 16'hEB01. carry=0, latency 3, alu_opcode equals input opcode in LO and HI.
5. Issue ADD 16'h0102+16'h0304, then pulse start_valid with different operands while busy -> ignored; done once, result=16'h0406; start_ready low from LO through DONE.
6. Assert rst_n=0 during HI of an ADD -> result=0, carry=0, no done pulse, start_ready=1. A subsequent ADD 16'h0007+16'h0007 -> result=16'h000E.

Bench uses a behavioural alu_8 (add/sub/and/or) wired to the alu_* ports.
